// File: rtl/flag_ctrl_pkg.sv
// flag_ctrl_pkg: shared encodings for the flag/branch controller.
//   - br_kind encoding (B.cond, CBZ, CBNZ, reserved)
//   - LEGv8 4-bit condition codes
//   - NZCV bit positions inside the 4-bit flags vector ({N,Z,C,V}, N = bit 3)
//   - FSM state type and the condition evaluation helper
package flag_ctrl_pkg;

    localparam logic [1:0] BR_BCOND = 2'b00;
    localparam logic [1:0] BR_CBZ   = 2'b01;
    localparam logic [1:0] BR_CBNZ  = 2'b10;
    localparam logic [1:0] BR_RSVD  = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Evaluate a condition code against an NZCV vector. AL and NV both pass.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_HS: cond_pass = c;
            COND_LO: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/flag_ctrl_flag_gen.sv
// flag_gen: combinational NZCV from the EX-stage ALU result.
// Ports:
//   result   [WIDTH-1:0] in  ALU result
//   carry               in  ALU carry-out
//   overflow            in  ALU signed overflow
//   nzcv     [3:0]      out {N,Z,C,V}, N = bit 3
module flag_gen
    import flag_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             overflow,
    output logic [3:0]       nzcv
);

    always_comb begin
        nzcv         = '0;
        nzcv[FLAG_N] = result[WIDTH-1];
        nzcv[FLAG_Z] = (result == '0);
        nzcv[FLAG_C] = carry;
        nzcv[FLAG_V] = overflow;
    end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: NZCV flag register and ID-stage branch resolver.
// Optional feature macro: FLAG_FWD_EN -- when defined, a B.cond that meets a
// flag-setting instruction in EX resolves against the EX flags the same cycle
// instead of stalling ID for one cycle.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   ex_valid, ex_set_flags        EX instruction valid / updates NZCV
//   ex_result, ex_carry, ex_overflow  ALU outputs feeding the flags
//   stall                         freeze everything except stall_cnt
//   flush                         squash EX and ID this cycle
//   br_valid, br_kind, br_cond, br_reg  ID-stage branch request
//   flags       [3:0]  committed {N,Z,C,V}
//   br_done            registered one-cycle "branch resolved" pulse
//   br_taken           registered outcome, 0 unless br_done
//   hazard_stall       combinational request to hold ID one cycle
//   stall_cnt   [15:0] saturating count of hazard_stall cycles
//   dbg_state          FSM state (0 = READY, 1 = HOLD)
// Handshake: a request is presented by holding br_valid with its fields
// stable; it is consumed on the edge where stall=0 and hazard_stall=0, and
// its result appears as br_done/br_taken after that edge.
module flag_ctrl
    import flag_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_carry,
    input  logic             ex_overflow,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [1:0]       br_kind,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_reg,
    output logic [3:0]       flags,
    output logic             br_done,
    output logic             br_taken,
    output logic             hazard_stall,
    output logic [15:0]      stall_cnt,
    output logic             dbg_state
);

    state_t     state;
    logic [3:0] held_cond;
    logic [3:0] ex_nzcv;
    logic       flag_wr;
    logic       flag_hazard;
    logic       br_outcome;

    flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result   (ex_result),
        .carry    (ex_carry),
        .overflow (ex_overflow),
        .nzcv     (ex_nzcv)
    );

    assign flag_wr     = ex_valid & ex_set_flags & ~stall & ~flush;
    // Only B.cond reads flags, so CBZ/CBNZ never collide with EX.
    assign flag_hazard = (state == ST_READY) & br_valid & (br_kind == BR_BCOND)
                         & ex_valid & ex_set_flags;
    assign dbg_state   = state;

    // Outcome of a non-hazard request, using the committed flags.
    always_comb begin
        br_outcome = 1'b0;
        case (br_kind)
            BR_BCOND: br_outcome = cond_pass(br_cond, flags);
            BR_CBZ:   br_outcome = (br_reg == '0);
            BR_CBNZ:  br_outcome = (br_reg != '0);
            default:  br_outcome = 1'b0;
        endcase
    end

`ifdef FLAG_FWD_EN
    assign hazard_stall = 1'b0;
`else
    // Stays up while stall holds the hazard in READY, so stall_cnt keeps
    // counting through an external stall.
    assign hazard_stall = ~reset & ~flush & flag_hazard;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_READY;
            held_cond <= '0;
            flags     <= '0;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
        end else begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            if (flag_wr) begin
                flags <= ex_nzcv;
            end
            if (flush) begin
                state <= ST_READY;
            end else if (!stall) begin
                case (state)
                    ST_READY: begin
                        if (br_valid) begin
                            held_cond <= br_cond;
                            if (flag_hazard) begin
`ifdef FLAG_FWD_EN
                                br_done  <= 1'b1;
                                br_taken <= cond_pass(br_cond, ex_nzcv);
`else
                                state <= ST_HOLD;
`endif
                            end else begin
                                br_done  <= 1'b1;
                                br_taken <= br_outcome;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // flags were written on the edge that entered HOLD.
                        br_done  <= 1'b1;
                        br_taken <= cond_pass(held_cond, flags);
                        state    <= ST_READY;
                    end
                    default: state <= ST_READY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hazard_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: self-checking bench for flag_ctrl (WIDTH = 64).
// Branch outcomes are predicted from a reference flag model and pushed to
// exp_q when a request is driven; the monitor pops them on br_done.
module tb_flag_ctrl;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         ex_valid;
    logic         ex_set_flags;
    logic [W-1:0] ex_result;
    logic         ex_carry;
    logic         ex_overflow;
    logic         stall;
    logic         flush;
    logic         br_valid;
    logic [1:0]   br_kind;
    logic [3:0]   br_cond;
    logic [W-1:0] br_reg;
    logic [3:0]   flags;
    logic         br_done;
    logic         br_taken;
    logic         hazard_stall;
    logic [15:0]  stall_cnt;
    logic         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0]  exp_q[$];
    logic [3:0]  model_flags;
    logic [15:0] exp_cnt;

    flag_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_result    (ex_result),
        .ex_carry     (ex_carry),
        .ex_overflow  (ex_overflow),
        .stall        (stall),
        .flush        (flush),
        .br_valid     (br_valid),
        .br_kind      (br_kind),
        .br_cond      (br_cond),
        .br_reg       (br_reg),
        .flags        (flags),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .hazard_stall (hazard_stall),
        .stall_cnt    (stall_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_nzcv(input logic [W-1:0] r, input logic c, input logic v);
        return {r[W-1], (r == 0), c, v};
    endfunction

    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [1:0] k, input logic [3:0] cc,
                                        input logic [W-1:0] r, input logic [3:0] f);
        case (k)
            2'b00: return ref_cond(cc, f);
            2'b01: return r == 0;
            2'b10: return r != 0;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (br_done) begin
                if (exp_q.size() == 0) check("unexp_done", br_done, 1'b0);
                else check("br_taken", br_taken, exp_q.pop_front());
            end else if (br_taken) begin
                check("taken_wo_done", br_taken, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_set_flags = 0; ex_result = '0; ex_carry = 0; ex_overflow = 0;
        stall = 0; flush = 0; br_valid = 0; br_kind = 2'b00; br_cond = 4'h0; br_reg = '0;
    endtask

    // Flag-setting EX op with no branch; updates the model.
    task automatic ex_op(input logic [W-1:0] r, input logic c, input logic v);
        ex_valid = 1; ex_set_flags = 1; ex_result = r; ex_carry = c; ex_overflow = v;
        model_flags = ref_nzcv(r, c, v);
        step();
        ex_valid = 0; ex_set_flags = 0;
        check("flags", flags, model_flags);
    endtask

    // Branch with EX idle; resolves against committed flags next edge.
    task automatic branch(input logic [1:0] k, input logic [3:0] cc, input logic [W-1:0] r);
        br_valid = 1; br_kind = k; br_cond = cc; br_reg = r;
        #1;
        check("no_hazard", hazard_stall, 1'b0);
        exp_q.push_back(ref_branch(k, cc, r, model_flags));
        step();
        br_valid = 0;
    endtask

    // B.cond colliding with a flag-setting EX op. Without forwarding this
    // leaves the DUT in HOLD with the request still presented.
    task automatic hazard(input logic [3:0] cc, input logic [W-1:0] r, input logic c, input logic v);
        br_valid = 1; br_kind = 2'b00; br_cond = cc; br_reg = '0;
        ex_valid = 1; ex_set_flags = 1; ex_result = r; ex_carry = c; ex_overflow = v;
        model_flags = ref_nzcv(r, c, v);
        #1;
`ifdef FLAG_FWD_EN
        check("hz_stall_fwd", hazard_stall, 1'b0);
        exp_q.push_back(ref_cond(cc, model_flags));
        step();
        br_valid = 0;
`else
        check("hz_stall", hazard_stall, 1'b1);
        exp_cnt = exp_cnt + 16'd1;
        step();
        check("hz_state_hold", dbg_state, 1'b1);
        check("hz_cnt", stall_cnt, exp_cnt);
        check("hz_no_done", br_done, 1'b0);
`endif
        ex_valid = 0; ex_set_flags = 0;
        check("hz_flags", flags, model_flags);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] r;
        idle();
        model_flags = 4'b0000;
        exp_cnt = 16'd0;
        reset = 1;
        // Hazard-shaped inputs while in reset: hazard_stall must stay low.
        br_valid = 1; ex_valid = 1; ex_set_flags = 1;
        #3;
        check("rst_hazard_stall", hazard_stall, 1'b0);
        check("rst_flags", flags, 4'b0000);
        check("rst_br_done", br_done, 1'b0);
        check("rst_br_taken", br_taken, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_state", dbg_state, 1'b0);
        step();
        idle();
        reset = 0;
        step();

        // SUBS giving zero then B.EQ
        ex_op(64'd0, 1'b0, 1'b0);
        check("subs_zero_flags", flags, 4'b0100);
        branch(2'b00, 4'h0, '0);
        step();

        // ADDS to MSB with overflow, then B.GE / B.LT back to back
        ex_op(64'h8000_0000_0000_0000, 1'b0, 1'b1);
        check("adds_msb_flags", flags, 4'b1001);
        branch(2'b00, 4'hA, '0);
        branch(2'b00, 4'hB, '0);
        step();

        // CBZ / CBNZ / reserved kind; a concurrent flag op is not a hazard
        branch(2'b01, 4'h0, 64'd0);
        branch(2'b10, 4'h0, 64'd5);
        branch(2'b11, 4'hE, 64'd0);
        ex_valid = 1; ex_set_flags = 1; ex_result = 64'd5; ex_carry = 1; ex_overflow = 0;
        branch(2'b01, 4'h0, 64'd7);
        model_flags = ref_nzcv(64'd5, 1'b1, 1'b0);
        ex_valid = 0; ex_set_flags = 0;
        step();
        check("flags_after_cbz", flags, model_flags);

        // B.NE against an in-flight SUBS producing zero (stale Z=0)
        hazard(4'h1, 64'd0, 1'b1, 1'b0);
`ifndef FLAG_FWD_EN
        #1;
        check("hold_hazard_low", hazard_stall, 1'b0);
        exp_q.push_back(ref_cond(4'h1, model_flags));
        step();
        br_valid = 0;
        check("hold_to_ready", dbg_state, 1'b0);
`endif
        step();

        // Random flag ops and branches over all condition codes
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 2))
                0: r = '0;
                1: r = 64'h8000_0000_0000_0000 | W'($urandom);
                default: r = {32'($urandom), 32'($urandom)};
            endcase
            ex_op(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            r = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 1000));
            branch(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 4'(i), r);
        end
        step();

        // Stall holds a pending CBZ and blocks a flag update
        stall = 1; br_valid = 1; br_kind = 2'b01; br_reg = '0;
        ex_valid = 1; ex_set_flags = 1; ex_result = 64'hFFFF_FFFF_FFFF_FFFF; ex_carry = 1; ex_overflow = 1;
        step();
        step();
        check("stall_flags_hold", flags, model_flags);
        check("stall_no_done", br_done, 1'b0);
        stall = 0; ex_valid = 0; ex_set_flags = 0;
        exp_q.push_back(1'b1);
        step();
        br_valid = 0;
        step();

        // Flush beats a flag update and drops a request
        flush = 1; br_valid = 1; br_kind = 2'b01; br_reg = '0;
        ex_valid = 1; ex_set_flags = 1; ex_result = 64'h8000_0000_0000_0000; ex_carry = 0; ex_overflow = 0;
        step();
        check("flush_flags_hold", flags, model_flags);
        check("flush_no_done", br_done, 1'b0);
        idle();
        step();

`ifndef FLAG_FWD_EN
        // Stall while in HOLD keeps the held branch
        hazard(4'h4, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        stall = 1;
        step();
        step();
        check("hold_stall_state", dbg_state, 1'b1);
        check("hold_stall_no_done", br_done, 1'b0);
        stall = 0;
        exp_q.push_back(ref_cond(4'h4, model_flags));
        step();
        br_valid = 0;
        step();

        // Flush in HOLD: back to READY, no resolution
        hazard(4'h0, 64'd0, 1'b0, 1'b0);
        flush = 1;
        step();
        check("flush_hold_state", dbg_state, 1'b0);
        check("flush_hold_no_done", br_done, 1'b0);
        idle();
        step();
        step();

        // Reset while in HOLD clears everything immediately
        hazard(4'h0, 64'd0, 1'b0, 1'b0);
        reset = 1;
        #1;
        check("rst_hold_flags", flags, 4'b0000);
        check("rst_hold_cnt", stall_cnt, 16'd0);
        check("rst_hold_state", dbg_state, 1'b0);
        check("rst_hold_hazard", hazard_stall, 1'b0);
        model_flags = 4'b0000;
        exp_cnt = 16'd0;
        step();
        idle();
        reset = 0;
        step();
        step();
        step();

        // Saturation: hazard held in READY by an external stall
        stall = 1; br_valid = 1; br_kind = 2'b00; br_cond = 4'h0;
        ex_valid = 1; ex_set_flags = 1; ex_result = 64'd3;
        for (int i = 0; i < 65534; i++) step();
        check("cnt_fffe", stall_cnt, 16'hFFFE);
        step();
        check("cnt_ffff", stall_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) step();
        check("cnt_saturated", stall_cnt, 16'hFFFF);
        check("sat_state", dbg_state, 1'b0);
        check("sat_flags", flags, model_flags);
        idle();
        step();
`endif

        step();
        step();
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_ctrl.md
FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 64: datapath width of the ALU result and CBZ operand.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ex_valid  in  1  EX-stage instruction valid.
REQ-006 ex_set_flags  in  1  EX instruction updates NZCV (ADDS/SUBS/ANDS).
REQ-007 ex_result  in  WIDTH  ALU result.
REQ-008 ex_carry, ex_overflow  in  1 each  ALU carry-out and signed overflow.
REQ-009 stall  in  1  pipeline stall; freezes all state except the counter.
REQ-010 flush  in  1  squash EX and ID this cycle.
REQ-011 br_valid  in  1  ID-stage branch request.
REQ-012 br_kind  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 reserved (never taken).
REQ-013 br_cond  in  4  LEGv8 condition code.
REQ-014 br_reg  in  WIDTH  CBZ/CBNZ operand.
REQ-015 flags  out  4  committed {N,Z,C,V}, bit 3 = N.
REQ-016 br_done  out  1  registered one-cycle pulse: branch resolved.
REQ-017 br_taken  out  1  registered branch outcome; valid only when br_done=1, else 0.
REQ-018 hazard_stall  out  1  combinational request to hold ID for one cycle.
REQ-019 stall_cnt  out  16  saturating count of hazard_stall cycles.

Function
REQ-020 Z SHALL be 1 iff ex_result == 0; N = ex_result[WIDTH-1]; C = ex_carry; V = ex_overflow.
REQ-021 flags SHALL load at the clock edge when ex_valid & ex_set_flags & ~stall & ~flush; otherwise they hold.
REQ-022 Conditions: EQ(0) Z; NE(1) ~Z; HS(2) C; LO(3) ~C; MI(4) N; PL(5) ~N; VS(6) V; VC(7) ~V; HI(8) C&~Z; LS(9) ~C|Z; GE(A) N==V; LT(B) N!=V; GT(C) ~Z&(N==V); LE(D) Z|(N!=V); AL(E,F) 1.
REQ-023 CBZ is taken iff br_reg == 0 and CBNZ iff br_reg != 0; neither uses or waits on flags.
REQ-024 FSM states: READY and HOLD; reset state is READY.
REQ-025 READY: a B.cond request with ex_valid & ex_set_flags is a flag hazard (resolution per REQ-033/034); any other request resolves against flags.
REQ-026 HOLD: hazard_stall=0; the held B.cond resolves against the just-updated flags; next state READY.
REQ-027 Resolution SHALL register br_done=1 and br_taken=outcome at the next edge (one-cycle latency).
REQ-028 stall=1 SHALL freeze state, suppress br_done and hold the pending request; flush=1 SHALL force READY and drop any pending or held request without br_done.
REQ-029 flush and ex_set_flags in the same cycle: flush wins; flags do not update.
REQ-030 stall_cnt SHALL increment on each cycle with hazard_stall=1, saturate at 0xFFFF and never wrap.

Reset
REQ-031 reset SHALL immediately set flags=0000, br_done=0, br_taken=0, stall_cnt=0 and the FSM to READY; a request in flight at reset is discarded.
REQ-032 hazard_stall SHALL be 0 while reset is asserted.

Configuration
REQ-033 With FLAG_FWD_EN defined, a READY flag hazard SHALL resolve against the EX-computed NZCV the same cycle (bypass), hazard_stall stays 0, HOLD is unreachable.
REQ-034 Without FLAG_FWD_EN, a READY flag hazard SHALL assert hazard_stall for exactly one cycle and enter HOLD.

Structure
REQ-035 The shared package SHALL hold the br_kind encoding, the 4-bit condition-code constants, and the NZCV bit-index constants.
REQ-036 One sub-module flag_gen SHALL compute combinational NZCV from ex_result/ex_carry/ex_overflow.

Verification
REQ-037 ex_result=0, SUBS -> flags=0100; next cycle B.EQ (0) -> br_done=1, br_taken=1.
REQ-038 ex_result=0x8000_0000_0000_0000, C=0, V=1, ADDS -> flags=1001; B.GE (A) -> br_taken=1; B.LT (B) -> br_taken=0.
REQ-039 B.NE issued while EX SUBS produces 0: FLAG_FWD_EN -> br_taken=0 with no stall; without -> hazard_stall=1 one cycle, stall_cnt=1, br_taken=0 the cycle after HOLD.
REQ-040 CBZ with br_reg=0 -> br_taken=1; CBNZ with br_reg=5 -> br_taken=1; br_kind=11 -> br_taken=0.
REQ-041 Assert reset while in HOLD -> outputs and counter clear immediately, no br_done follows; flush in HOLD -> READY, no br_done.
REQ-042 Force 65540 hazard stalls (macro undefined) -> stall_cnt saturates at 0xFFFF.
